// File: rtl/spi_daisy_if.sv
// Bus bundle for the daisy-chain SPI master: start handshake, frame data,
// serial pins and status. The master modport is the controller side.
interface spi_daisy_if #(
    parameter int FRAME_W = 16
);
    logic               newd;
    logic [FRAME_W-1:0] din;
    logic               miso;
    logic               sclk;
    logic               cs;
    logic               mosi;
    logic [FRAME_W-1:0] dout;
    logic               busy;
    logic               done;

    modport master (
        input  newd, din, miso,
        output sclk, cs, mosi, dout, busy, done
    );

    modport slave (
        output newd, din, miso,
        input  sclk, cs, mosi, dout, busy, done
    );
endinterface

// File: rtl/spi_daisy_master.sv
// SPI master that shifts one N_DEV*DATA_W frame through a daisy chain of
// devices sharing one chip select. All outputs are registered.
module spi_daisy_master #(
    parameter int DATA_W = 8,
    parameter int N_DEV  = 2,
    parameter int HALF   = 2,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic         clk,
    input  logic         rst,
    spi_daisy_if.master  bus
);
    localparam int   FRAME_W  = N_DEV * DATA_W;
    localparam int   EDGES    = 2 * FRAME_W;
    localparam int   CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int   EDGE_W   = $clog2(EDGES + 1);
    localparam logic IDLE_LVL = 1'(CPOL);
    localparam logic PHA      = 1'(CPHA);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [EDGE_W-1:0]   edge_r, edge_s;
    logic [FRAME_W-1:0]  tx_r, tx_s;
    logic [FRAME_W-1:0]  rx_r, rx_s;
    logic [FRAME_W-1:0]  dout_r, dout_s;
    logic                sclk_r, sclk_s;
    logic                cs_r, cs_s;
    logic                mosi_r, mosi_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    logic                half_end_s;
    logic                fire_s;
    logic                last_s;
    logic                sample_s;

    // Edge bookkeeping: the next edge is leading when an even number of edges
    // has already been produced; the sampling edge depends on CPHA.
    always_comb begin
        half_end_s = (cnt_r == CNT_W'(HALF - 1));
        fire_s     = half_end_s && ((state_r == ST_SETUP) || (state_r == ST_SHIFT));
        last_s     = (edge_r == EDGE_W'(EDGES - 1));
        sample_s   = (~edge_r[0]) ^ PHA;
    end

    // Next-state and next-output logic; the datapath defaults come first and the
    // state case overrides control fields.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cs_s    = cs_r;
        busy_s  = busy_r;
        dout_s  = dout_r;
        done_s  = 1'b0;

        if (fire_s) begin
            sclk_s = ~sclk_r;
            edge_s = edge_r + EDGE_W'(1);
            if (sample_s) begin
                rx_s   = (rx_r << 1) | FRAME_W'(bus.miso);
                tx_s   = tx_r;
                mosi_s = mosi_r;
            end else if (!last_s) begin
                // tx_r always holds the bits not yet presented, MSB first
                rx_s   = rx_r;
                tx_s   = tx_r << 1;
                mosi_s = tx_r[FRAME_W-1];
            end else begin
                rx_s   = rx_r;
                tx_s   = tx_r;
                mosi_s = mosi_r;
            end
        end else begin
            sclk_s = sclk_r;
            edge_s = edge_r;
            rx_s   = rx_r;
            tx_s   = tx_r;
            mosi_s = mosi_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_s  = {CNT_W{1'b0}};
                edge_s = {EDGE_W{1'b0}};
                sclk_s = IDLE_LVL;
                if (bus.newd) begin
                    state_s = ST_SETUP;
                    cs_s    = 1'b0;
                    busy_s  = 1'b1;
                    rx_s    = {FRAME_W{1'b0}};
                    if (PHA) begin
                        tx_s   = bus.din;
                        mosi_s = 1'b0;
                    end else begin
                        // MSB is already on the wire, so keep only the rest
                        tx_s   = bus.din << 1;
                        mosi_s = bus.din[FRAME_W-1];
                    end
                end else begin
                    cs_s   = 1'b1;
                    busy_s = 1'b0;
                    mosi_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (half_end_s) begin
                    state_s = ST_SHIFT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (half_end_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (last_s) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (half_end_s) begin
                    state_s = ST_GAP;
                    cnt_s   = {CNT_W{1'b0}};
                    cs_s    = 1'b1;
                    done_s  = 1'b1;
                    dout_s  = rx_r;
                    mosi_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (half_end_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                edge_s  = {EDGE_W{1'b0}};
                sclk_s  = IDLE_LVL;
                cs_s    = 1'b1;
                busy_s  = 1'b0;
                mosi_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            edge_r  <= {EDGE_W{1'b0}};
            tx_r    <= {FRAME_W{1'b0}};
            rx_r    <= {FRAME_W{1'b0}};
            dout_r  <= {FRAME_W{1'b0}};
            sclk_r  <= IDLE_LVL;
            cs_r    <= 1'b1;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            edge_r  <= edge_s;
            tx_r    <= tx_s;
            rx_r    <= rx_s;
            dout_r  <= dout_s;
            sclk_r  <= sclk_s;
            cs_r    <= cs_s;
            mosi_r  <= mosi_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.sclk = sclk_r;
    assign bus.cs   = cs_r;
    assign bus.mosi = mosi_r;
    assign bus.dout = dout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_spi_daisy_master.sv
// Directed bench for spi_daisy_master: a default instance (loopback or a
// two-device chain model) and a CPOL=1/CPHA=1/HALF=3/N_DEV=3 loopback instance.
module tb_spi_daisy_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_daisy_if #(.FRAME_W(16)) bus_a ();
    spi_daisy_if #(.FRAME_W(24)) bus_b ();

    spi_daisy_master dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    spi_daisy_master #(.DATA_W(8), .N_DEV(3), .HALF(3), .CPOL(1), .CPHA(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Two 8-bit chained devices: chain[15:8] is the far device, chain[7:0] the near one.
    logic        loop_a     = 1'b1;
    logic        chain_load = 1'b0;
    logic [15:0] chain      = 16'h0000;
    always @(posedge bus_a.sclk or posedge chain_load) begin
        if (chain_load) chain <= 16'hC33C;
        else            chain <= {chain[14:0], bus_a.mosi};
    end
    assign bus_a.miso = loop_a ? bus_a.mosi : chain[15];
    assign bus_b.miso = bus_b.mosi;

    // Free-running activity counters, read only while the DUTs are idle.
    int   edges_a = 0, rises_a = 0, dones_a = 0, edges_b = 0;
    logic sclk_prev_a = 1'b0, sclk_prev_b = 1'b1;
    always @(negedge clk) begin
        sclk_prev_a <= bus_a.sclk;
        sclk_prev_b <= bus_b.sclk;
        if (bus_a.sclk !== sclk_prev_a) edges_a <= edges_a + 1;
        if (bus_a.sclk === 1'b1 && sclk_prev_a === 1'b0) rises_a <= rises_a + 1;
        if (bus_a.done === 1'b1) dones_a <= dones_a + 1;
        if (bus_b.sclk !== sclk_prev_b) edges_b <= edges_b + 1;
    end

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [15:0] d, input logic [15:0] exp);
        bus_a.din  = d;
        bus_a.newd = 1'b1;
        exp_a.push_back({8'h00, exp});
        @(negedge clk);
        bus_a.newd = 1'b0;
    endtask

    // Waits (bounded) for done on instance A, then pops and checks the scoreboard.
    task automatic wait_done_a(input string tag, input int budget, output int lat);
        logic [23:0] e;
        lat = 0;
        while (bus_a.done !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_timeout"}, 64'(lat < budget), 64'd1);
        if (bus_a.done === 1'b1) begin
            if (exp_a.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                e = exp_a.pop_front();
                check({tag, "_dout"}, 64'(bus_a.dout), 64'(e[15:0]));
            end
        end
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (bus_a.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 64'(n < 200), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, lat2, n, e0, r0, d0, eb;
        logic [23:0] eb_val;
        rst = 1'b1;
        bus_a.newd = 1'b0; bus_a.din = 16'h0000;
        bus_b.newd = 1'b0; bus_b.din = 24'h000000;
        repeat (3) @(negedge clk);
        check("rst_sclk_a", 64'(bus_a.sclk), 64'd0);
        check("rst_cs_a",   64'(bus_a.cs),   64'd1);
        check("rst_mosi_a", 64'(bus_a.mosi), 64'd0);
        check("rst_dout_a", 64'(bus_a.dout), 64'd0);
        check("rst_busy_a", 64'(bus_a.busy), 64'd0);
        check("rst_done_a", 64'(bus_a.done), 64'd0);
        check("rst_sclk_b", 64'(bus_b.sclk), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback frame, default timing
        e0 = edges_a; d0 = dones_a;
        start_a(16'hA55A, 16'hA55A);
        check("lb_cs_low", 64'(bus_a.cs),   64'd0);
        check("lb_busy",   64'(bus_a.busy), 64'd1);
        check("lb_mosi0",  64'(bus_a.mosi), 64'd1);
        wait_done_a("lb", 200, lat);
        check("lb_latency", 64'(lat), 64'd66);
        check("lb_cs_rise", 64'(bus_a.cs), 64'd1);
        wait_idle_a("lb");
        check("lb_edges", 64'(edges_a - e0), 64'd32);
        check("lb_dones", 64'(dones_a - d0), 64'd1);
        check("lb_idle_mosi", 64'(bus_a.mosi), 64'd0);
        check("lb_idle_sclk", 64'(bus_a.sclk), 64'd0);

        // Two-device chain
        loop_a = 1'b0;
        chain_load = 1'b1; #1 chain_load = 1'b0;
        @(negedge clk);
        start_a(16'h1234, 16'hC33C);
        wait_done_a("chain", 200, lat);
        wait_idle_a("chain");
        check("chain_far",  64'(chain[15:8]), 64'h12);
        check("chain_near", 64'(chain[7:0]),  64'h34);
        loop_a = 1'b1;

        // newd pulsed mid-frame with a different din must be ignored
        r0 = rises_a; d0 = dones_a;
        start_a(16'h5A3C, 16'h5A3C);
        repeat (20) @(negedge clk);
        bus_a.din = 16'hFFFF; bus_a.newd = 1'b1;
        @(negedge clk);
        bus_a.newd = 1'b0;
        wait_done_a("renewd", 200, lat);
        check("renewd_latency", 64'(lat + 21), 64'd66);
        wait_idle_a("renewd");
        check("renewd_rises", 64'(rises_a - r0), 64'd16);
        check("renewd_dones", 64'(dones_a - d0), 64'd1);

        // Reset after the 5th bit aborts the frame; rst wins over newd
        r0 = rises_a; d0 = dones_a;
        start_a(16'hF0F0, 16'hF0F0);
        n = 0;
        while ((rises_a - r0) < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach5", 64'(n < 100), 64'd1);
        rst = 1'b1; bus_a.newd = 1'b1; bus_a.din = 16'hAAAA;
        @(negedge clk);
        check("abort_cs",   64'(bus_a.cs),   64'd1);
        check("abort_sclk", 64'(bus_a.sclk), 64'd0);
        check("abort_busy", 64'(bus_a.busy), 64'd0);
        check("abort_dout", 64'(bus_a.dout), 64'd0);
        check("abort_done", 64'(bus_a.done), 64'd0);
        @(negedge clk);
        check("abort_rst_prio_cs", 64'(bus_a.cs), 64'd1);
        rst = 1'b0; bus_a.newd = 1'b0;
        void'(exp_a.pop_back());
        repeat (80) @(negedge clk);
        check("abort_no_done", 64'(dones_a - d0), 64'd0);
        start_a(16'h00FF, 16'h00FF);
        wait_done_a("post_abort", 200, lat);
        check("post_abort_latency", 64'(lat), 64'd66);
        wait_idle_a("post_abort");

        // Back-to-back with newd held; din changes after the latch
        bus_a.din = 16'h6B9D; bus_a.newd = 1'b1;
        exp_a.push_back(24'h006B9D);
        exp_a.push_back(24'h008E21);
        @(negedge clk);
        bus_a.din = 16'h8E21;
        wait_done_a("b2b_1", 200, lat);
        n = 0;
        while (bus_a.cs !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap", 64'(n), 64'd3);
        bus_a.newd = 1'b0;
        wait_done_a("b2b_2", 200, lat2);
        check("b2b_2_latency", 64'(lat2), 64'd66);
        wait_idle_a("b2b");

        // CPOL=1, CPHA=1, HALF=3, 24-bit loopback instance
        eb = edges_b;
        bus_b.din = 24'hDEADBE; bus_b.newd = 1'b1;
        exp_b.push_back(24'hDEADBE);
        @(negedge clk);
        bus_b.newd = 1'b0;
        bus_b.din = 24'h123456;
        check("b_cs_low", 64'(bus_b.cs),   64'd0);
        check("b_mosi0",  64'(bus_b.mosi), 64'd0);
        check("b_sclk_setup", 64'(bus_b.sclk), 64'd1);
        n = 0;
        while (bus_b.done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", 64'(n), 64'd147);
        if (bus_b.done === 1'b1 && exp_b.size() > 0) begin
            eb_val = exp_b.pop_front();
            check("b_dout", 64'(bus_b.dout), 64'(eb_val));
        end else begin
            check("b_done_seen", 64'd0, 64'd1);
        end
        repeat (8) @(negedge clk);
        check("b_edges", 64'(edges_b - eb), 64'd48);
        check("b_idle_sclk", 64'(bus_b.sclk), 64'd1);
        check("b_idle_busy", 64'(bus_b.busy), 64'd0);

        check("sb_drained", 64'(exp_a.size() + exp_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
